// File: rtl/sevga_pkg.sv
// Shared definitions for the SE video path: frame buffer location, write-FSM
// states and the layout of one queued CPU write.
package sevga_pkg;

    localparam logic [23:0] FB_BASE_DEFAULT = 24'h3FA700;
    localparam int          FB_SIZE_DEFAULT = 21888;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } wrState_t;

    typedef struct packed {
        logic [13:0] offset;
        logic [15:0] data;
        logic [1:0]  mask;
    } fifoEntry_t;

endpackage

// File: rtl/vramwr_fifo.sv
// Small synchronous queue of pending CPU writes; the head entry is visible
// combinationally so the write FSM can start on the cycle it becomes eligible.
module vramwr_fifo
    import sevga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       pixClock,
    input  logic       nReset,
    input  logic       push,
    input  fifoEntry_t pushEntry,
    input  logic       pop,
    output fifoEntry_t headEntry,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    fifoEntry_t       mem [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W:0]   countReg;
    logic             doPush;
    logic             doPop;

    assign full   = (countReg == (PTR_W+1)'(DEPTH));
    assign empty  = (countReg == '0);
    // A push into a full queue is still accepted when the head leaves on the same edge.
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    assign headEntry = mem[rdPtrReg];

    always_ff @(posedge pixClock) begin
        if (doPush) begin
            mem[wrPtrReg] <= pushEntry;
        end
    end

    always_ff @(posedge pixClock) begin
        if (!nReset) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + (PTR_W+1)'(1);
                2'b01:   countReg <= countReg - (PTR_W+1)'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Captures 68000 writes that land in the main screen buffer, queues them and
// replays them to VRAM one byte at a time, clear of the video fetch slot.
module vram_writer
    import sevga_pkg::*;
#(
    parameter logic [23:0] FB_BASE    = FB_BASE_DEFAULT,
    parameter int          FB_SIZE    = FB_SIZE_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        pixClock,
    input  logic        nReset,
    input  logic [22:0] cpuAddr,
    input  logic [15:0] cpuData,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        cpuRnW,
    input  logic [9:0]  hCount,
    output logic [14:0] vramAddr,
    output logic [7:0]  vramDataOut,
    output logic        vramDataOE,
    output logic        nvramWE,
    output logic        vramCpuSel,
    output logic        fifoFull,
    output logic        overflow
);

    localparam logic [24:0] FB_END = 25'(FB_BASE) + 25'(FB_SIZE);

    logic [2:0] strobeRaw;
    logic [2:0] strobeSync;

    assign strobeRaw = {nAS, nUDS, nLDS};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gStrobeSync
            logic stage1Reg;
            logic stage2Reg;
            always_ff @(posedge pixClock) begin
                if (!nReset) begin
                    stage1Reg <= 1'b1;
                    stage2Reg <= 1'b1;
                end else begin
                    stage1Reg <= strobeRaw[gi];
                    stage2Reg <= stage1Reg;
                end
            end
            assign strobeSync[gi] = stage2Reg;
        end
    endgenerate

    logic asSync, udsSync, ldsSync;
    assign asSync  = strobeSync[2];
    assign udsSync = strobeSync[1];
    assign ldsSync = strobeSync[0];

    logic        armedReg;
    logic        capture;
    logic        inRange;
    logic [13:0] relWord;
    logic        pushReq;
    fifoEntry_t  pushEntry;

    assign capture = armedReg && !asSync && !cpuRnW && (!udsSync || !ldsSync);
    assign inRange = ({cpuAddr, 1'b0} >= FB_BASE) && ({1'b0, cpuAddr, 1'b0} < FB_END);
    // Word offset from the buffer base, borrowing correctly even for an odd base.
    assign relWord = cpuAddr[13:0] - FB_BASE[14:1] - 14'(FB_BASE[0]);
    assign pushReq = capture && inRange;
    assign pushEntry = '{offset: relWord, data: cpuData, mask: {~udsSync, ~ldsSync}};

    fifoEntry_t headEntry;
    logic       fifoEmpty;
    logic       pop;

    vramwr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .pixClock (pixClock),
        .nReset   (nReset),
        .push     (pushReq),
        .pushEntry(pushEntry),
        .pop      (pop),
        .headEntry(headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    wrState_t    stateReg, stateNext;
    logic        upperDoneReg;
    logic        loadWrite;
    logic        writeLower;
    logic        lastByte;
    logic [14:0] vramAddrReg;
    logic [7:0]  vramDataReg;

    assign writeLower  = upperDoneReg || !headEntry.mask[1];
    assign lastByte    = writeLower || !headEntry.mask[0];
    assign vramAddr    = vramAddrReg;
    assign vramDataOut = vramDataReg;

    always_comb begin
        stateNext  = stateReg;
        pop        = 1'b0;
        loadWrite  = 1'b0;
        vramCpuSel = 1'b0;
        vramDataOE = 1'b0;
        nvramWE    = 1'b1;
        case (stateReg)
            IDLE: begin
                // Starting in pixels 0-3 keeps the 3-cycle write clear of pixel 7.
                if (!fifoEmpty && !hCount[2]) begin
                    stateNext = SETUP;
                    loadWrite = 1'b1;
                end
            end
            SETUP: begin
                vramCpuSel = 1'b1;
                vramDataOE = 1'b1;
                stateNext  = STROBE;
            end
            STROBE: begin
                vramCpuSel = 1'b1;
                vramDataOE = 1'b1;
                nvramWE    = 1'b0;
                stateNext  = HOLD;
            end
            HOLD: begin
                vramCpuSel = 1'b1;
                vramDataOE = 1'b1;
                pop        = lastByte;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge pixClock) begin
        if (!nReset) begin
            stateReg     <= IDLE;
            upperDoneReg <= 1'b0;
            armedReg     <= 1'b0;
            overflow     <= 1'b0;
            vramAddrReg  <= '0;
            vramDataReg  <= '0;
        end else begin
            stateReg <= stateNext;
            if (asSync) begin
                armedReg <= 1'b1;
            end else if (capture) begin
                armedReg <= 1'b0;
            end
            if (pushReq && fifoFull && !pop) begin
                overflow <= 1'b1;
            end
            if (loadWrite) begin
                vramAddrReg <= {headEntry.offset, writeLower};
                vramDataReg <= writeLower ? headEntry.data[7:0] : headEntry.data[15:8];
            end
            if (stateReg == HOLD) begin
                upperDoneReg <= !lastByte;
            end
        end
    end

    logic unusedHCount;
    assign unusedHCount = ^hCount[9:3];

endmodule
